// File: rtl/traffic_ctrl.sv
// Two-way intersection traffic-light controller with per-road seconds-remaining
// counters and a night-mode flashing-yellow override, advanced by a 1 Hz tick.
`timescale 1ns/1ps
module traffic_ctrl #(
  parameter int T_MG = 25,
  parameter int T_MY = 3,
  parameter int T_SG = 20,
  parameter int T_SY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       night,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic [5:0] main_cnt,
  output logic [5:0] side_cnt
);

  typedef enum logic [2:0] {
    MG_SR = 3'd0,
    MY_SR = 3'd1,
    MR_SG = 3'd2,
    MR_SY = 3'd3,
    FLASH = 3'd4
  } state_t;

  // Phase durations, i.e. the value each counter is loaded with on entering a phase.
  localparam logic [5:0] LD_MG = 6'(T_MG);
  localparam logic [5:0] LD_MY = 6'(T_MY);
  localparam logic [5:0] LD_MR = 6'(T_SG + T_SY);
  localparam logic [5:0] LD_SR = 6'(T_MG + T_MY);
  localparam logic [5:0] LD_SG = 6'(T_SG);
  localparam logic [5:0] LD_SY = 6'(T_SY);

  state_t     state, state_d;
  logic [5:0] main_d, side_d;
  logic       blink, blink_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MG_SR;
      main_cnt <= LD_MG;
      side_cnt <= LD_SR;
      blink    <= 1'b0;
    end else begin
      state    <= state_d;
      main_cnt <= main_d;
      side_cnt <= side_d;
      blink    <= blink_d;
    end
  end

  // NOTE: every variable gets a hold default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    main_d  = main_cnt;
    side_d  = side_cnt;
    blink_d = blink;
    if (tick) begin
      if (state == FLASH) begin
        if (night) begin
          blink_d = ~blink;
        end else begin
          state_d = MG_SR;
          main_d  = LD_MG;
          side_d  = LD_SR;
          blink_d = 1'b0;
        end
      end else if (night) begin
        state_d = FLASH;
        main_d  = 6'd0;
        side_d  = 6'd0;
        blink_d = 1'b1;
      end else begin
        main_d = main_cnt - 6'd1;
        side_d = side_cnt - 6'd1;
        // The road whose lamp changes reads 1 on the tick that ends its phase.
        case (state)
          MG_SR: if (main_cnt == 6'd1) begin
            state_d = MY_SR;
            main_d  = LD_MY;
          end
          MY_SR: if (main_cnt == 6'd1) begin
            state_d = MR_SG;
            main_d  = LD_MR;
            side_d  = LD_SG;
          end
          MR_SG: if (side_cnt == 6'd1) begin
            state_d = MR_SY;
            side_d  = LD_SY;
          end
          MR_SY: if (main_cnt == 6'd1) begin
            state_d = MG_SR;
            main_d  = LD_MG;
            side_d  = LD_SR;
          end
          default: ;
        endcase
      end
    end
  end

  // Lamps are a pure decode of the registered state and blink bit.
  always_comb begin
    main_r = 1'b0;
    main_y = 1'b0;
    main_g = 1'b0;
    side_r = 1'b0;
    side_y = 1'b0;
    side_g = 1'b0;
    case (state)
      MG_SR: begin main_g = 1'b1; side_r = 1'b1; end
      MY_SR: begin main_y = 1'b1; side_r = 1'b1; end
      MR_SG: begin main_r = 1'b1; side_g = 1'b1; end
      MR_SY: begin main_r = 1'b1; side_y = 1'b1; end
      FLASH: begin main_y = blink; side_y = blink; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl: default timing instance plus an all-ones
// timing instance; stimulus pushes expected responses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_traffic_ctrl;

  typedef struct packed {
    logic [5:0] lamps;  // {main_r, main_y, main_g, side_r, side_y, side_g}
    logic [5:0] mc;
    logic [5:0] sc;
  } resp_t;

  logic clk = 1'b0;
  logic rst, tick, tick2, night, probe;
  logic pend1 = 1'b0, pend2 = 1'b0;

  logic       m_r1, m_y1, m_g1, s_r1, s_y1, s_g1;
  logic [5:0] mc1, sc1;
  logic       m_r2, m_y2, m_g2, s_r2, s_y2, s_g2;
  logic [5:0] mc2, sc2;

  resp_t q1[$];
  resp_t q2[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  traffic_ctrl dut1 (
    .clk(clk), .rst(rst), .tick(tick), .night(night),
    .main_r(m_r1), .main_y(m_y1), .main_g(m_g1),
    .side_r(s_r1), .side_y(s_y1), .side_g(s_g1),
    .main_cnt(mc1), .side_cnt(sc1)
  );

  traffic_ctrl #(.T_MG(1), .T_MY(1), .T_SG(1), .T_SY(1)) dut2 (
    .clk(clk), .rst(rst), .tick(tick2), .night(1'b0),
    .main_r(m_r2), .main_y(m_y2), .main_g(m_g2),
    .side_r(s_r2), .side_y(s_y2), .side_g(s_g2),
    .main_cnt(mc2), .side_cnt(sc2)
  );

  // Expected response p ticks into a normal cycle, derived from elapsed time.
  function automatic resp_t exp_norm(int p, int tmg, int tmy, int tsg, int tsy);
    resp_t r;
    int per;
    per = tmg + tmy + tsg + tsy;
    if (p < tmg) begin
      r.lamps = 6'b001_100; r.mc = 6'(tmg - p); r.sc = 6'(tmg + tmy - p);
    end else if (p < tmg + tmy) begin
      r.lamps = 6'b010_100; r.mc = 6'(tmg + tmy - p); r.sc = 6'(tmg + tmy - p);
    end else if (p < tmg + tmy + tsg) begin
      r.lamps = 6'b100_001; r.mc = 6'(per - p); r.sc = 6'(tmg + tmy + tsg - p);
    end else begin
      r.lamps = 6'b100_010; r.mc = 6'(per - p); r.sc = 6'(per - p);
    end
    return r;
  endfunction

  function automatic resp_t exp_def(int p);
    return exp_norm(p % 51, 25, 3, 20, 3);
  endfunction

  function automatic resp_t exp_flash(logic b);
    resp_t r;
    r.lamps = {1'b0, b, 1'b0, 1'b0, b, 1'b0};
    r.mc    = 6'd0;
    r.sc    = 6'd0;
    return r;
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A response is due on the edge after any tick, reset or probe request.
  always @(posedge clk) begin
    pend1 <= tick | rst | probe;
    pend2 <= tick2 | rst;
  end

  always @(negedge clk) begin
    resp_t a, e;
    if (pend1) begin
      a = {m_r1, m_y1, m_g1, s_r1, s_y1, s_g1, mc1, sc1};
      if (q1.size() == 0) begin
        check("dut1_unexpected_response", a, 18'h0_0000 ^ ~a);
      end else begin
        e = q1.pop_front();
        check("dut1_resp", a, e);
        if (e.mc != 6'd0)
          check("dut1_one_lamp_per_road",
                18'({$countones(a.lamps[5:3]) == 1, $countones(a.lamps[2:0]) == 1}), 18'd3);
      end
    end
    if (pend2) begin
      a = {m_r2, m_y2, m_g2, s_r2, s_y2, s_g2, mc2, sc2};
      if (q2.size() == 0) begin
        check("dut2_unexpected_response", a, ~a);
      end else begin
        e = q2.pop_front();
        check("dut2_resp", a, e);
        check("dut2_one_lamp_per_road",
              18'({$countones(a.lamps[5:3]) == 1, $countones(a.lamps[2:0]) == 1}), 18'd3);
      end
    end
  end

  task automatic apply_rst(input int n);
    rst = 1'b1; tick = 1'b1; tick2 = 1'b1; night = 1'b1;
    repeat (n) begin
      q1.push_back(exp_def(0));
      q2.push_back(exp_norm(0, 1, 1, 1, 1));
      @(posedge clk); #1;
    end
    rst = 1'b0; tick = 1'b0; tick2 = 1'b0; night = 1'b0;
  endtask

  task automatic tick1(input logic n, input resp_t e);
    night = n;
    tick  = 1'b1;
    q1.push_back(e);
    @(posedge clk); #1;
    tick  = 1'b0;
  endtask

  task automatic probe1(input resp_t e);
    probe = 1'b1;
    q1.push_back(e);
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; tick2 = 1'b0; night = 1'b0; probe = 1'b0;
    @(posedge clk); #1;

    // Reset dominates tick and night.
    apply_rst(2);

    // Full default cycle, back-to-back ticks: 51 ticks returns to the start.
    for (int k = 1; k <= 51; k++) tick1(1'b0, exp_def(k));

    // Advance to main_cnt = 10 in MG_SR.
    for (int k = 1; k <= 15; k++) tick1(1'b0, exp_def(k));

    // Hold for 100 clks with no tick; night pulses between ticks are ignored.
    for (int i = 0; i < 100; i++) begin
      night = (i >= 30 && i < 60);
      @(posedge clk); #1;
    end
    night = 1'b0;
    probe1(exp_def(15));

    // Night entry, blink toggling, night exit.
    tick1(1'b1, exp_flash(1'b1));
    tick1(1'b1, exp_flash(1'b0));
    tick1(1'b1, exp_flash(1'b1));
    tick1(1'b1, exp_flash(1'b0));
    tick1(1'b0, exp_def(0));
    tick1(1'b0, exp_def(1));

    // Flash holds without tick, then reset from FLASH.
    tick1(1'b1, exp_flash(1'b1));
    repeat (5) begin @(posedge clk); #1; end
    probe1(exp_flash(1'b1));
    apply_rst(1);

    // Reset mid-phase.
    for (int k = 1; k <= 30; k++) tick1(1'b0, exp_def(k));
    apply_rst(1);

    // All-ones timing: state advances every tick, period 4.
    for (int k = 1; k <= 8; k++) begin
      tick2 = 1'b1;
      q2.push_back(exp_norm(k % 4, 1, 1, 1, 1));
      @(posedge clk); #1;
    end
    tick2 = 1'b0;

    repeat (3) begin @(posedge clk); #1; end
    check("dut1_queue_drained", 18'(q1.size()), 18'd0);
    check("dut2_queue_drained", 18'(q2.size()), 18'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
